// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   CLKS_PER_BIT_9600 : clocks per bit at 9600 baud from the 100 MHz master clock
//   UART_DATA_BITS    : data bits per frame (8N1)
//   UART_IDLE_LEVEL   : level of an idle line, which is also the stop-bit level
//   uart_rx_state_t   : receiver FSM state encoding
package uart_pkg;

    localparam int   CLKS_PER_BIT_9600 = 10416;
    localparam int   UART_DATA_BITS    = 8;
    localparam logic UART_IDLE_LEVEL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        CLEANUP  = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage flop chain that brings an asynchronous level into the clk domain.
// Usable for any slow asynchronous input (serial lines, buttons, switches).
//   clk : destination clock
//   rst : synchronous, active-high; loads RST_VAL into every stage
//   d   : asynchronous input
//   q   : synchronised output, STAGES cycles behind d
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= {STAGES{RST_VAL}};
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
//   clk       : master clock
//   rst       : synchronous, active-high reset
//   rx_serial : asynchronous serial line, idle high
//   rx_byte   : last correctly framed byte, held until the next good frame
//   rx_dv     : one-cycle strobe, rx_byte newly updated
//   rx_busy   : high whenever the FSM is not in IDLE
//   frame_err : one-cycle strobe, stop bit sampled low
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | line idle, waiting for a low level on rx_sync
// RX_START | timing half a bit into the start bit to confirm it is real
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_STOP  | sampling the stop bit; issue rx_dv or frame_err
// CLEANUP  | waiting for the line to return high before re-arming
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_dv,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    logic rx_sync;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_sync)
    );

    uart_rx_state_t state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      dv_q, dv_d;
    logic                      ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_sync != UART_IDLE_LEVEL) begin
                    state_d = RX_START;
                end
            end

            RX_START: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (cnt_q == HALF_TC) begin
                    state_d = (rx_sync == UART_IDLE_LEVEL) ? IDLE : RX_DATA;
                end
            end

            RX_DATA: begin
                if (cnt_q == BIT_TC) begin
                    // Bit periods are not always a power of two; wrap explicitly.
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            RX_STOP: begin
                if (cnt_q == BIT_TC) begin
                    if (rx_sync == UART_IDLE_LEVEL) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = CLEANUP;
                end
            end

            CLEANUP: begin
                // Holding here on a low line keeps a break from looking like a new start bit.
                cnt_d = '0;
                if (rx_sync == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign rx_byte   = byte_q;
    assign rx_dv     = dv_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = SYNC + 1 + HALF + 9 * CPB;
    localparam int TOL  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_dv     (rx_dv),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    logic [7:0] got_byte_q[$];
    int         got_cyc_q[$];
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;

    always @(negedge clk) begin
        if (rx_dv) begin
            got_byte_q.push_back(rx_byte);
            got_cyc_q.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (rx_dv && frame_err) overlap_cnt++;
    end

    // Reference model: what a receiver should report for the frames sent
    logic [7:0] exp_byte_q[$];
    int         exp_cyc_q[$];
    int         exp_ferr  = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; drives one full 8N1 frame, each bit CPB cycles.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        int t0;
        t0 = cyc;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        check("busy_in_frame", rx_busy, 1);
        for (int i = 0; i < 8; i++) begin
            rx_serial = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop;
        repeat (CPB) @(negedge clk);
        if (stop) begin
            exp_byte_q.push_back(data);
            exp_cyc_q.push_back(t0 + LAT);
            last_good = data;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic drain(input string tag);
        int d;
        check({tag, "_dv_count"}, got_byte_q.size(), exp_byte_q.size());
        while (got_byte_q.size() > 0 && exp_byte_q.size() > 0) begin
            check({tag, "_byte"}, got_byte_q.pop_front(), exp_byte_q.pop_front());
            d = got_cyc_q.pop_front() - exp_cyc_q.pop_front();
            total++;
            assert (d >= -TOL && d <= TOL) else begin
                bad++;
                $error("FAIL %s_latency observed_offset=%0d expected=0+-%0d", tag, d, TOL);
            end
        end
        got_byte_q.delete();
        got_cyc_q.delete();
        exp_byte_q.delete();
        exp_cyc_q.delete();
        check({tag, "_ferr_count"}, ferr_cnt, exp_ferr);
        check({tag, "_rx_byte"}, rx_byte, last_good);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_hi;
        logic [7:0] rb;

        rst       = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_rx_dv", rx_dv, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;

        // Idle line
        busy_hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (rx_busy) busy_hi++;
        end
        check("idle_busy_cycles", busy_hi, 0);
        drain("idle");

        // Single byte
        send_frame(8'hA5, 1'b1);
        check("a5_busy_after", rx_busy, 0);
        drain("a5");

        // Back to back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        drain("b2b");

        // Glitch shorter than half a bit
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial = 1'b1;
        check("glitch_busy_start", rx_busy, 1);
        repeat (30) @(negedge clk);
        check("glitch_busy_end", rx_busy, 0);
        drain("glitch");

        // Framing error with line held low afterwards
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_cleanup_busy", rx_busy, 1);
        drain("ferr");
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_release_busy", rx_busy, 0);
        send_frame(8'h81, 1'b1);
        drain("after_ferr");

        // Reset mid data bits of 8'hC3
        rb = 8'hC3;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_serial = rb[i];
            repeat (CPB) @(negedge clk);
        end
        rst       = 1'b1;
        rx_serial = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("midrst_rx_byte", rx_byte, 0);
        check("midrst_rx_dv", rx_dv, 0);
        check("midrst_rx_busy", rx_busy, 0);
        check("midrst_frame_err", frame_err, 0);
        repeat (100) @(negedge clk);
        drain("midrst");
        send_frame(8'h7E, 1'b1);
        drain("after_rst");

        // Random bytes with short random gaps
        for (int i = 0; i < 10; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        drain("random");

        check("dv_ferr_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: deserialises the asynchronous `rx_serial` line into bytes, LSB first.
- Partner of the existing UART transmitter: same 100 MHz master clock, same 9600 baud default, same bit timing.
- Delivers each received byte with a one-cycle `rx_dv` strobe.
- Flags a missing stop bit as a framing error.

Parameters:
- `CLKS_PER_BIT`, 10416, clocks per bit period (100 MHz / 9600 baud); must be >= 8.
- `SYNC_STAGES`, 2, number of flops in the input metastability synchroniser; must be >= 2.

Ports:
- `clk`  in  1  master clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial line; idle high.
- `rx_byte`  out  8  last correctly framed byte; held until the next valid byte.
- `rx_dv`  out  1  one-cycle pulse; `rx_byte` is valid and newly updated in that cycle.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse; stop bit was sampled low.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; counters, bit index and shift register cleared.
  - All synchroniser flops set to 1.
  - `rx_byte`=0, `rx_dv`=0, `rx_busy`=0, `frame_err`=0.
  - Reset asserted mid-frame aborts the frame: no `rx_dv`, no `frame_err`.
- `rx_sync`: `rx_serial` after `SYNC_STAGES` flops. The FSM reads only `rx_sync`.
- `HALF` = (`CLKS_PER_BIT`-1)/2, integer division.
- Counter width: $clog2(`CLKS_PER_BIT`). Counter resets to 0 on every state change.
- IDLE:
  - Counter=0, bit index=0.
  - `rx_sync`==0 -> RX_START.
- RX_START:
  - Count 0..`HALF`-1. At count==`HALF`-1, sample `rx_sync`.
  - Sample 0 -> RX_DATA, counter=0.
  - Sample 1 -> IDLE (glitch rejected; no output activity).
- RX_DATA:
  - Count 0..`CLKS_PER_BIT`-1. At terminal count, shift register[bit index] <= `rx_sync`.
  - Bit index 0..6: increment bit index.
  - Bit index 7: bit index=0, -> RX_STOP.
  - Samples therefore land at mid-bit.
- RX_STOP:
  - Count 0..`CLKS_PER_BIT`-1, then sample `rx_sync`.
  - Sample 1: `rx_byte` <= shift register; `rx_dv`=1 for exactly one cycle.
  - Sample 0: `frame_err`=1 for exactly one cycle; `rx_byte` unchanged; no `rx_dv`.
  - Either case -> CLEANUP.
- CLEANUP:
  - Stay until `rx_sync`==1, then -> IDLE.
  - Blocks re-triggering on a break or stuck-low line.
  - Minimum residency 1 cycle.
- `rx_dv` and `frame_err` are never high in the same cycle; both are registered.
- Latency:
  - Falling edge on `rx_serial` to `rx_dv` = `SYNC_STAGES` + 1 + `HALF` + 9*`CLKS_PER_BIT` cycles.
  - Bench tolerance is ±3 cycles.
- Back-to-back frames:
  - A start bit immediately following a valid stop bit must be received.
  - CLEANUP exits on the high stop level, so IDLE is reached before the next start edge (margin is half a bit).
- Tolerates ±2% baud mismatch against the transmitter. No parity, no FIFO, no overrun detection.
  - Consumer must read `rx_byte` before the next `rx_dv`; the byte is overwritten only by the next `rx_dv`.
- Out-of-range state encoding -> IDLE.

Decomposition:
- Package `uart_pkg`, shared with the transmitter:
  - `CLKS_PER_BIT_9600` = 10416.
  - Typedef `uart_rx_state_t` (IDLE, RX_START, RX_DATA, RX_STOP, CLEANUP; 3-bit logic enum).
  - Constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1'b1.
- Sub-module `sync_ff`:
  - Parameterised N-stage synchroniser, reset value parameter = 1.
  - Reusable for other asynchronous inputs (buttons, switches).

Test Plan (bench uses `CLKS_PER_BIT`=16, `HALF`=7):
- Reset then idle line high for 200 cycles -> `rx_dv`, `frame_err` and `rx_busy` stay 0; `rx_byte`=8'h00.
- Send 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single `rx_dv` pulse ~150 cycles after start edge; `rx_byte`=8'hA5; `rx_busy` falls after stop.
- Send back-to-back 8'h00, 8'hFF, 8'h3C with no idle gap -> three `rx_dv` pulses with `rx_byte` 8'h00, 8'hFF, 8'h3C in order.
- Glitch: drive `rx_serial` low for 4 cycles then high -> FSM returns to IDLE; no `rx_dv`, no `frame_err`.
- Framing error: send 8'h55 with stop bit 0, hold line low 40 cycles, then high:
  - `frame_err` pulses once; `rx_byte` keeps its previous value; FSM remains in CLEANUP until line high.
  - A following 8'h81 is received correctly.
- Assert `rst` for 1 cycle mid-RX_DATA of 8'hC3 -> all outputs 0, IDLE next cycle, no `rx_dv`. A subsequent clean 8'h7E is received.
